// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch control outputs shared between the pipeline
// datapath and its hazard/sequencing controller.
interface pipeline_ctrl_if;
  // Hazard sources reported by the datapath
  logic       ihit;
  logic       dhit;
  logic       mem_dREN;
  logic       mem_dWEN;
  logic       ex_dREN;
  logic [4:0] ex_regDst;
  logic [4:0] de_rs;
  logic [4:0] de_rt;
  logic       de_use_rt;
  logic       de_halt;
  logic       ex_redirect;

  // Latch controls returned by the controller
  logic       pc_en;
  logic       ifde_en;
  logic       ifde_flush;
  logic       deex_en;
  logic       deex_flush;
  logic       exmem_en;
  logic       memwb_en;
  logic       halt;

  // Datapath side
  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst,
           de_rs, de_rt, de_use_rt, de_halt, ex_redirect,
    input  pc_en, ifde_en, ifde_flush, deex_en, deex_flush,
           exmem_en, memwb_en, halt
  );

  // Controller side
  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst,
           de_rs, de_rt, de_use_rt, de_halt, ex_redirect,
    output pc_en, ifde_en, ifde_flush, deex_en, deex_flush,
           exmem_en, memwb_en, halt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: memory-wait
// freeze, redirect squash, load-use stall, icache-miss bubble, halt drain
// and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  pipeline_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;

  logic mem_wait;
  logic lu;
  logic go_drain;
  logic pc_en, ifde_en, ifde_flush, deex_en, deex_flush;
  logic exmem_en, memwb_en, halt;

  assign mem_wait = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign lu = bus.ex_dREN && (bus.ex_regDst != 5'd0) &&
              ((bus.ex_regDst == bus.de_rs) ||
               (bus.de_use_rt && (bus.ex_regDst == bus.de_rt)));

  // Latch controls decoded from current state and hazard inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    pc_en      = 1'b0;
    ifde_en    = 1'b0;
    ifde_flush = 1'b0;
    deex_en    = 1'b0;
    deex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halt       = 1'b0;
    go_drain   = 1'b0;
    if (RST) begin
      ifde_flush = 1'b1;
      deex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_wait) begin
            // Freeze: everything holds.
          end else if (bus.ex_redirect) begin
            // Redirect wins over a younger halt: it is on the wrong path.
            {pc_en, ifde_en, deex_en, exmem_en, memwb_en} = '1;
            ifde_flush = 1'b1;
            deex_flush = 1'b1;
          end else if (lu || bus.de_halt) begin
            // Hold fetch/decode, inject a bubble into EX.
            deex_en    = 1'b1;
            deex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            go_drain   = ~lu;
          end else if (!bus.ihit) begin
            // Icache miss: bubble into decode, older stages move on.
            ifde_en    = 1'b1;
            ifde_flush = 1'b1;
            deex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            {pc_en, ifde_en, deex_en, exmem_en, memwb_en} = '1;
          end
        end
        HALT_DRAIN: begin
          if (!mem_wait) begin
            deex_en    = 1'b1;
            deex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end
        end
        HALTED:  halt = 1'b1;
        default: halt = 1'b0;
      endcase
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifde_en    = ifde_en;
  assign bus.ifde_flush = ifde_flush;
  assign bus.deex_en    = deex_en;
  assign bus.deex_flush = deex_flush;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.halt       = halt;

  // State, drain countdown and saturating stall counter.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (RST) begin
      state     <= RUN;
      dcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == RUN && !pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        RUN: begin
          if (go_drain) begin
            state <= HALT_DRAIN;
            dcnt  <= DW'(DRAIN_CYCLES);
          end
        end
        HALT_DRAIN: begin
          if (!mem_wait) begin
            dcnt <= dcnt - 1'b1;
            if (dcnt == DW'(1))
              state <= HALTED;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random traffic, all compared with a behavioural model of the pipeline
// control rules.
module tb_pipeline_ctrl;
  localparam int DRAIN = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [CW-1:0] stall_cnt;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus.slave),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic       mem_rd;
    logic       mem_wr;
    logic       ex_rd;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       de_halt;
    logic       redir;
  } stim_t;

  int checks = 0;
  int errors = 0;

  // Model: 0 = running, 1 = draining, 2 = halted
  int m_mode  = 0;
  int m_left  = 0;
  int m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latch action as seen by the datapath: 2 = loads NOP, 1 = loads, 0 = holds.
  function automatic logic [1:0] act(input logic flush, input logic en);
    return flush ? 2'd2 : (en ? 2'd1 : 2'd0);
  endfunction

  // Apply one cycle of stimulus, compare against the model, then clock.
  task automatic step(input stim_t s, input string tag);
    logic       wait_mem, hazard;
    logic       e_pc, e_xm, e_wb, e_halt;
    logic [1:0] e_if, e_de;
    int         mode_before;
    RST           = s.rst;
    bus.ihit      = s.ihit;
    bus.dhit      = s.dhit;
    bus.mem_dREN  = s.mem_rd;
    bus.mem_dWEN  = s.mem_wr;
    bus.ex_dREN   = s.ex_rd;
    bus.ex_regDst = s.dst;
    bus.de_rs     = s.rs;
    bus.de_rt     = s.rt;
    bus.de_use_rt = s.use_rt;
    bus.de_halt   = s.de_halt;
    bus.ex_redirect = s.redir;
    #1;
    if (s.rst) begin
      m_mode = 0; m_left = 0; m_stall = 0;
      check({tag, ".rst_ctl"},
            {bus.pc_en, bus.ifde_en, bus.ifde_flush, bus.deex_en,
             bus.deex_flush, bus.exmem_en, bus.memwb_en, bus.halt},
            8'b0010_1000);
      check({tag, ".rst_cnt"}, stall_cnt, 0);
    end else begin
      wait_mem = (s.mem_rd || s.mem_wr) && !s.dhit;
      hazard   = s.ex_rd && s.dst != 0 &&
                 (s.dst == s.rs || (s.use_rt && s.dst == s.rt));
      {e_pc, e_if, e_de, e_xm, e_wb, e_halt} = '0;
      mode_before = m_mode;
      if (m_mode == 2) begin
        e_halt = 1'b1;
      end else if (wait_mem) begin
        // frozen: all hold
      end else if (m_mode == 1) begin
        e_de = 2; e_xm = 1; e_wb = 1;
        m_left--;
        if (m_left == 0) m_mode = 2;
      end else if (s.redir) begin
        e_pc = 1; e_if = 2; e_de = 2; e_xm = 1; e_wb = 1;
      end else if (hazard || s.de_halt) begin
        e_de = 2; e_xm = 1; e_wb = 1;
        if (!hazard) begin m_mode = 1; m_left = DRAIN; end
      end else if (!s.ihit) begin
        e_if = 2; e_de = 1; e_xm = 1; e_wb = 1;
      end else begin
        e_pc = 1; e_if = 1; e_de = 1; e_xm = 1; e_wb = 1;
      end
      check({tag, ".ctl"},
            {bus.pc_en, act(bus.ifde_flush, bus.ifde_en),
             act(bus.deex_flush, bus.deex_en), bus.exmem_en, bus.memwb_en, bus.halt},
            {e_pc, e_if, e_de, e_xm, e_wb, e_halt});
      check({tag, ".cnt"}, stall_cnt, m_stall);
      if (mode_before == 0 && !e_pc && m_stall < CMAX) m_stall++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    stim_t idle, s;
    idle = '0;
    idle.ihit = 1'b1;
    idle.dhit = 1'b1;

    // Reset state
    s = idle; s.rst = 1'b1;
    step(s, "reset0");
    step(s, "reset1");

    // Load-use on rs: one stall cycle then normal flow
    s = idle; s.ex_rd = 1; s.dst = 5'd8; s.rs = 5'd8;
    step(s, "lu_rs");
    check("lu_cnt1", stall_cnt, 1);
    step(idle, "lu_after");

    // Load into r0 never stalls
    s = idle; s.rst = 1; step(s, "rst_a");
    s = idle; s.ex_rd = 1; s.dst = 5'd0; s.rs = 5'd0;
    step(s, "lu_r0");
    check("lu_r0_cnt", stall_cnt, 0);

    // Load-use through rt only when rt is read
    s = idle; s.ex_rd = 1; s.dst = 5'd5; s.rt = 5'd5; s.use_rt = 1;
    step(s, "lu_rt");
    s.use_rt = 0;
    step(s, "lu_rt_unused");

    // Memory wait dominates lu and redirect for 4 cycles
    s = idle; s.rst = 1; step(s, "rst_b");
    s = idle; s.mem_rd = 1; s.dhit = 0; s.ex_rd = 1; s.dst = 5'd3; s.rs = 5'd3; s.redir = 1;
    for (int i = 0; i < 4; i++) step(s, "mwait");
    check("mwait_cnt4", stall_cnt, 4);
    s.dhit = 1;
    step(s, "mwait_release");
    check("redir_pc_en", bus.pc_en, 1);

    // Store wait also freezes
    s = idle; s.mem_wr = 1; s.dhit = 0;
    step(s, "swait");

    // Halt on a redirect's wrong path is ignored
    s = idle; s.de_halt = 1; s.redir = 1;
    step(s, "halt_wrong_path");
    step(idle, "still_run");

    // Halt drain with a 2-cycle memory wait in the middle
    s = idle; s.rst = 1; step(s, "rst_c");
    s = idle; s.de_halt = 1;
    step(s, "halt_decode");
    step(idle, "drain1");
    s = idle; s.mem_rd = 1; s.dhit = 0; s.ex_rd = 1; s.dst = 5'd1; s.rs = 5'd1;
    step(s, "drain_wait1");
    step(s, "drain_wait2");
    s = idle; s.ihit = 0; s.redir = 1;
    step(s, "drain2");
    step(s, "drain3");
    check("halted", bus.halt, 1);
    step(idle, "halted1");
    step(idle, "halted2");
    check("halted_cnt", stall_cnt, 1);
    s = idle; s.rst = 1; step(s, "rst_exit");
    step(idle, "run_again");
    check("run_halt0", bus.halt, 0);

    // Icache miss for 20 cycles saturates the counter
    s = idle; s.ihit = 0;
    for (int i = 0; i < 20; i++) step(s, "imiss");
    check("sat_cnt", stall_cnt, CMAX);
    check("sat_flush", bus.ifde_flush, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s        = '0;
      s.rst    = ($urandom_range(0, 99) < 2);
      s.ihit   = ($urandom_range(0, 99) < 80);
      s.dhit   = ($urandom_range(0, 99) < 70);
      s.mem_rd = ($urandom_range(0, 99) < 25);
      s.mem_wr = ($urandom_range(0, 99) < 15);
      s.ex_rd  = ($urandom_range(0, 99) < 40);
      s.dst    = 5'($urandom_range(0, 3));
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.use_rt = 1'($urandom);
      s.de_halt = ($urandom_range(0, 99) < 6);
      s.redir  = ($urandom_range(0, 99) < 12);
      step(s, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Drives enable and flush for the PC and the IF/DE, DE/EX, EX/MEM and MEM/WB latches, where DE/EX is the latch fed by the decode outputs.
- Resolves memory-wait freezes, taken-branch/jump squashes, load-use stalls and icache misses.
- Sequences processor halt: drains older instructions, then asserts halt.
- Keeps a saturating stall-cycle counter for performance visibility.

Parameters:
- DRAIN_CYCLES, 3, advancing cycles spent draining EX/MEM/WB after halt is decoded.
- CNT_W, 16, width of stall_cnt.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- ihit  input  1  instruction fetch complete this cycle.
- dhit  input  1  data access complete this cycle.
- mem_dREN  input  1  MEM-stage instruction is a load.
- mem_dWEN  input  1  MEM-stage instruction is a store.
- ex_dREN  input  1  EX-stage instruction is a load.
- ex_regDst  input  5  EX-stage destination register.
- de_rs  input  5  decode-stage rs.
- de_rt  input  5  decode-stage rt.
- de_use_rt  input  1  decode-stage instruction reads rt.
- de_halt  input  1  decode-stage instruction is halt.
- ex_redirect  input  1  EX resolved a taken branch or jump; PC loads the target.
- pc_en  output  1  PC update enable.
- ifde_en  output  1  IF/DE latch enable.
- ifde_flush  output  1  IF/DE latch loads NOP.
- deex_en  output  1  DE/EX latch enable.
- deex_flush  output  1  DE/EX latch loads NOP.
- exmem_en  output  1  EX/MEM latch enable.
- memwb_en  output  1  MEM/WB latch enable.
- halt  output  1  processor halted.
- stall_cnt  output  CNT_W  saturating count of RUN cycles with pc_en=0.

Behaviour:
- Flush takes priority over enable at the latch. These definitions apply to every condition below:
  - "Advance": all enables 1, no flush.
  - "Freeze": all enables 0, all flushes 0.
- State register: RUN, HALT_DRAIN, HALTED, plus drain counter dcnt (width clog2(DRAIN_CYCLES+1)).
- Outputs are combinational from state and inputs; state, dcnt and stall_cnt are registered.
- While RST is high:
  - state=RUN, dcnt=0, stall_cnt=0.
  - All enables 0, ifde_flush=1, deex_flush=1, halt=0.
  - Reset asserted mid-drain or in HALTED returns to RUN immediately.
- Derived terms:
  - mem_wait = (mem_dREN|mem_dWEN) & ~dhit.
  - lu = ex_dREN & (ex_regDst!=0) & ((ex_regDst==de_rs) | (de_use_rt & ex_regDst==de_rt)).
- RUN, first matching condition wins:
  1. mem_wait: freeze.
  2. ex_redirect: advance, plus ifde_flush=1 and deex_flush=1. de_halt is ignored (wrong path).
  3. lu: pc_en=0, ifde_en=0, deex_flush=1; EX/MEM and MEM/WB advance.
  4. de_halt: pc_en=0, ifde_en=0, deex_flush=1 (the halt itself is squashed); rest advance. Next state HALT_DRAIN, dcnt=DRAIN_CYCLES.
  5. ~ihit: pc_en=0, ifde_flush=1; DE/EX, EX/MEM, MEM/WB advance.
  6. Otherwise advance.
- HALT_DRAIN:
  - mem_wait: freeze; dcnt holds.
  - Otherwise: pc_en=0, ifde_en=0, deex_flush=1, exmem_en=1, memwb_en=1; dcnt decrements.
  - When dcnt==1 on an advancing cycle, next state is HALTED.
  - Result: exactly DRAIN_CYCLES advancing cycles; ihit, ex_redirect and lu are ignored.
- HALTED: all enables 0, flushes 0, halt=1. Only RST exits.
- stall_cnt increments on each RUN cycle with pc_en=0 (conditions 1, 3, 4, 5; not 2). Saturates at all ones; no wrap.
- Register 0 never causes a load-use stall.

Test Plan:
- ex_dREN=1, ex_regDst=8, de_rs=8, ihit=1, dhit=1 -> exactly 1 cycle pc_en=0, ifde_en=0, deex_flush=1; stall_cnt 0->1; next cycle (ex_dREN=0) all enables 1.
- Same as above but ex_regDst=0, de_rs=0 -> no stall; all enables 1; stall_cnt stays 0.
- mem_dREN=1, dhit=0 for 4 cycles while lu=1 and ex_redirect=1 -> all enables and flushes 0 for 4 cycles, stall_cnt=4. Cycle dhit=1 -> redirect response (pc_en=1, ifde_flush=1, deex_flush=1).
- de_halt=1 with ex_redirect=1 -> halt ignored, flushes asserted, state stays RUN.
- de_halt=1, no hazards, dhit low for 2 cycles mid-drain -> HALT_DRAIN holds 3 advancing + 2 frozen cycles; halt=1 on the 6th cycle and stays 1; RST pulse -> halt=0, state RUN.
- CNT_W=4, ihit=0 for 20 cycles -> stall_cnt saturates at 15; ifde_flush=1 each of those cycles.
